// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment scan path: segment patterns ({g,f,e,d,c,b,a}),
// slot indices and edit-field encodings.
package disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [2:0] SLOT_SEC_L = 3'd0;
  localparam logic [2:0] SLOT_SEC_M = 3'd1;
  localparam logic [2:0] SLOT_MIN_L = 3'd2;
  localparam logic [2:0] SLOT_MIN_M = 3'd3;
  localparam logic [2:0] SLOT_HR_L  = 3'd4;
  localparam logic [2:0] SLOT_HR_M  = 3'd5;

  typedef enum logic [1:0] {
    EDIT_NONE = 2'd0,
    EDIT_SEC  = 2'd1,
    EDIT_MIN  = 2'd2,
    EDIT_HR   = 2'd3
  } edit_t;

  function automatic logic [5:0] slot_onehot(input logic [2:0] s);
    return 6'b000001 << s;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Six-digit multiplexed 7-segment scanner with frame snapshot, dead time,
// edit-field blinking, leading-zero blanking and colon dots.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 4,
  parameter int BLINK_FRAMES = 64,
  parameter int LZ_BLANK     = 1
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [3:0] Sec_Least,
  input  logic [3:0] Sec_Most,
  input  logic [3:0] Min_Least,
  input  logic [3:0] Min_Most,
  input  logic [3:0] Hr_Least,
  input  logic [3:0] Hr_Most,
  input  logic [1:0] Edit_field,
  input  logic       Colon_en,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [5:0] Dig_en,
  output logic       Frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc;
  logic [2:0]    slot;
  logic [3:0]    snap [6];
  logic          blink;
  logic [FW-1:0] frame_cnt;
  edit_t         edit_q;
  logic          wrap_q;

  logic       tick;
  logic       wrap;
  logic [3:0] cur_digit;
  logic [6:0] cur_seg;
  logic       edit_hit;
  logic       lz_hit;

  assign tick = (presc == PW'(SCAN_DIV - 1));
  assign wrap = tick && (slot == SLOT_HR_M);

  always_comb begin
    cur_digit = snap[0];
    case (slot)
      SLOT_SEC_L: cur_digit = snap[0];
      SLOT_SEC_M: cur_digit = snap[1];
      SLOT_MIN_L: cur_digit = snap[2];
      SLOT_MIN_M: cur_digit = snap[3];
      SLOT_HR_L:  cur_digit = snap[4];
      SLOT_HR_M:  cur_digit = snap[5];
      default:    cur_digit = snap[0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // Edit pairs map onto slot[2:1]: sec -> 0, min -> 1, hr -> 2.
  assign edit_hit = blink && (edit_q != EDIT_NONE) &&
                    (slot[2:1] == (2'(edit_q) - 2'd1));
  assign lz_hit   = (LZ_BLANK != 0) && (slot == SLOT_HR_M) && (cur_digit == 4'd0);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      slot        <= SLOT_SEC_L;
      for (int i = 0; i < 6; i++) snap[i] <= '0;
      blink       <= 1'b0;
      frame_cnt   <= '0;
      edit_q      <= EDIT_NONE;
      wrap_q      <= 1'b0;
      Seg         <= SEG_BLANK;
      Dp          <= 1'b0;
      Dig_en      <= '0;
      Frame_start <= 1'b0;
    end else begin
      if (tick) begin
        presc <= '0;
        slot  <= (slot == SLOT_HR_M) ? SLOT_SEC_L : slot + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end

      if (wrap) begin
        snap[0] <= Sec_Least;
        snap[1] <= Sec_Most;
        snap[2] <= Min_Least;
        snap[3] <= Min_Most;
        snap[4] <= Hr_Least;
        snap[5] <= Hr_Most;
      end

      edit_q <= edit_t'(Edit_field);
      if (edit_t'(Edit_field) != edit_q) begin
        frame_cnt <= '0;
        blink     <= 1'b0;
      end else if (wrap) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      // wrap_q marks the cycle where slot 0 is current, so Frame_start lines up with its Seg.
      wrap_q      <= wrap;
      Frame_start <= wrap_q;
      Seg         <= (edit_hit || lz_hit) ? SEG_BLANK : cur_seg;
      Dp          <= Colon_en && !blink && ((slot == SLOT_MIN_L) || (slot == SLOT_HR_L));
      Dig_en      <= (presc < PW'(DEAD)) ? 6'b000000 : slot_onehot(slot);
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized self-checking bench for disp_scan_ctrl against a cycle-count based reference model.
module tb_disp_scan_ctrl;

  localparam int S   = 4;
  localparam int DT  = 1;
  localparam int BF  = 2;
  localparam int FRM = 6 * S;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [3:0] Sec_Least, Sec_Most, Min_Least, Min_Most, Hr_Least, Hr_Most;
  logic [1:0] Edit_field;
  logic       Colon_en;
  logic [6:0] Seg;
  logic       Dp;
  logic [5:0] Dig_en;
  logic       Frame_start;

  disp_scan_ctrl #(
    .SCAN_DIV     (S),
    .DEAD         (DT),
    .BLINK_FRAMES (BF),
    .LZ_BLANK     (1)
  ) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .Sec_Least   (Sec_Least),
    .Sec_Most    (Sec_Most),
    .Min_Least   (Min_Least),
    .Min_Most    (Min_Most),
    .Hr_Least    (Hr_Least),
    .Hr_Most     (Hr_Most),
    .Edit_field  (Edit_field),
    .Colon_en    (Colon_en),
    .Seg         (Seg),
    .Dp          (Dp),
    .Dig_en      (Dig_en),
    .Frame_start (Frame_start)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] segtab [16];

  // Reference model state: edges since release, shown frame, blink bookkeeping.
  int         k_m;
  int         shown [6];
  int         blink_m;
  int         frames_m;
  int         edit_m;
  int         rst_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t k=%0d", tag, got, exp, $time, k_m);
    end
  endtask

  task automatic model_reset();
    k_m      = 0;
    blink_m  = 0;
    frames_m = 0;
    edit_m   = 0;
    for (int i = 0; i < 6; i++) shown[i] = 0;
  endtask

  function automatic int input_digit(input int idx);
    case (idx)
      0: return int'(Sec_Least);
      1: return int'(Sec_Most);
      2: return int'(Min_Least);
      3: return int'(Min_Most);
      4: return int'(Hr_Least);
      default: return int'(Hr_Most);
    endcase
  endfunction

  // One clock: predict outputs of the edge just taken, compare, then advance the model.
  task automatic step();
    int         pos, slot, val;
    logic [6:0] e_seg;
    logic [5:0] e_dig;
    logic       e_dp, e_fs, blank;
    @(negedge CLK);
    pos   = k_m % FRM;
    slot  = pos / S;
    val   = shown[slot];
    blank = (blink_m == 1 && edit_m != 0 && slot / 2 == edit_m - 1) ||
            (slot == 5 && val == 0);
    e_seg = blank ? 7'd0 : segtab[val];
    e_dig = ((pos % S) < DT) ? 6'd0 : 6'(1 << slot);
    e_dp  = (slot == 2 || slot == 4) && Colon_en && blink_m == 0;
    e_fs  = (k_m >= FRM) && (pos == 0);
    check("seg",         32'(Seg),         32'(e_seg));
    check("dig_en",      32'(Dig_en),      32'(e_dig));
    check("dp",          32'(Dp),          32'(e_dp));
    check("frame_start", 32'(Frame_start), 32'(e_fs));

    if (pos == FRM - 1)
      for (int i = 0; i < 6; i++) shown[i] = input_digit(i);
    if (int'(Edit_field) != edit_m) begin
      frames_m = 0;
      blink_m  = 0;
    end else if (pos == FRM - 1) begin
      if (frames_m == BF - 1) begin
        frames_m = 0;
        blink_m  = 1 - blink_m;
      end else begin
        frames_m++;
      end
    end
    edit_m = int'(Edit_field);
    k_m++;
  endtask

  task automatic check_reset_outputs();
    check("rst_seg",   32'(Seg),         32'd0);
    check("rst_dig",   32'(Dig_en),      32'd0);
    check("rst_dp",    32'(Dp),          32'd0);
    check("rst_fs",    32'(Frame_start), 32'd0);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge CLK);
    check_reset_outputs();
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  task automatic randomize_inputs();
    if ($urandom_range(0, 29) == 0) begin
      case ($urandom_range(0, 5))
        0: Sec_Least = rand_digit();
        1: Sec_Most  = rand_digit();
        2: Min_Least = rand_digit();
        3: Min_Most  = rand_digit();
        4: Hr_Least  = rand_digit();
        default: Hr_Most = ($urandom_range(0, 2) == 0) ? rand_digit() : 4'($urandom_range(0, 1));
      endcase
    end
    if ($urandom_range(0, 149) == 0) Edit_field = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 99) == 0)  Colon_en   = ~Colon_en;
  endtask

  initial begin
    segtab[0] = 7'b0111111; segtab[1] = 7'b0000110; segtab[2] = 7'b1011011;
    segtab[3] = 7'b1001111; segtab[4] = 7'b1100110; segtab[5] = 7'b1101101;
    segtab[6] = 7'b1111101; segtab[7] = 7'b0000111; segtab[8] = 7'b1111111;
    segtab[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) segtab[i] = 7'b1000000;

    rst_n      = 1'b0;
    Hr_Most    = 4'd1; Hr_Least  = 4'd2;
    Min_Most   = 4'd3; Min_Least = 4'd4;
    Sec_Most   = 4'd5; Sec_Least = 4'd6;
    Edit_field = 2'd0;
    Colon_en   = 1'b1;
    rst_cnt    = 0;
    model_reset();

    repeat (3) @(negedge CLK);
    check_reset_outputs();
    rst_n = 1'b1;

    // Fixed 12:34:56 for two frames, then Sec_Least changes mid-frame at slot 2.
    repeat (2 * FRM + 2 * S + 1) step();
    Sec_Least = 4'd7;
    repeat (2 * FRM) step();
    Hr_Most = 4'd0; Hr_Least = 4'd9;
    repeat (2 * FRM) step();
    Hr_Most = 4'd1;
    Sec_Least = 4'hC;
    repeat (2 * FRM) step();
    Edit_field = 2'd2;
    repeat (3 * FRM + 5) step();
    Edit_field = 2'd3;
    repeat (2 * FRM) step();

    // Reset in the middle of slot 3.
    while ((k_m % FRM) != 3 * S + 1) step();
    pulse_reset();
    repeat (2 * FRM + 3) step();

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
      if (rst_cnt < 3 && i > 700 * (rst_cnt + 1) && (k_m % FRM) == 3 * S + 2) begin
        rst_cnt++;
        pulse_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
